// File: rtl/fc_pkg.sv
// Shared types and constants for the fault-countermeasure voter.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VOTE    = 2'd2,
    ST_HOLD    = 2'd3
  } fc_state_e;

  localparam int FC_SKEW_DEF = 8;
  localparam int FC_CW_DEF   = 8;

  // Bits needed to hold values 0..v-1 (minimum 1).
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fc_bit_majority.sv
// Combinational bitwise majority across NREP replicated words of width W.
module fc_bit_majority
  import fc_pkg::*;
#(
  parameter int W    = 8,
  parameter int NREP = 3
) (
  input  logic [NREP*W-1:0] vec_i,
  output logic [W-1:0]      maj_o
);

  function automatic logic col_major(input logic [NREP*W-1:0] v, input int b);
    int ones;
    ones = 0;
    for (int i = 0; i < NREP; i++) ones += int'(v[i*W+b]);
    return (ones > NREP / 2);
  endfunction

  always_comb begin
    maj_o = '0;
    for (int b = 0; b < W; b++) maj_o[b] = col_major(vec_i, b);
  end

endmodule

// File: rtl/fc_vote_seq.sv
// Sequential N-way redundancy voter with skew window and fault masking.
// Optional macro FC_FAULT_CNT_EN adds the saturating fault counter.
//
// state   | meaning
// IDLE    | waiting for start
// COLLECT | capturing replica results inside the skew window
// VOTE    | one-cycle bitwise vote, outputs registered
// HOLD    | result presented until out_ack
module fc_vote_seq
  import fc_pkg::*;
#(
  parameter int NREP   = 3,
  parameter int Y      = 40,
  parameter int T      = 128,
  parameter int QUORUM = NREP / 2 + 1,
  parameter int SKEW   = FC_SKEW_DEF,
  parameter int CW     = FC_CW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NREP-1:0]   rep_ready,
  input  logic [NREP*Y-1:0] rep_ct,
  input  logic [NREP*T-1:0] rep_tag,
  input  logic [Y-1:0]      random_fault_ct,
  input  logic [T-1:0]      random_fault_tag,
  input  logic              out_ack,
  output logic [Y-1:0]      cipher_text,
  output logic [T-1:0]      tag,
  output logic              encryption_ready,
  output logic              fault_detect,
  output logic              skew_timeout,
  output logic [CW-1:0]     fault_count
);

  localparam int SKW = clog2(SKEW + 1);
  localparam int MW  = clog2(NREP + 1);

  fc_state_e         state_q, state_d;
  logic [NREP-1:0]   cap_q, cap_d, new_cap;
  logic [NREP*Y-1:0] cap_ct_q, cap_ct_d;
  logic [NREP*T-1:0] cap_tag_q, cap_tag_d;
  logic [SKW-1:0]    win_q, win_d;
  logic [Y-1:0]      ct_q, maj_ct;
  logic [T-1:0]      tag_q, maj_tag;
  logic              fd_q, to_q;
  logic [MW-1:0]     match;
  logic              vote_fault, vote_ok, win_end;

  assign new_cap = rep_ready & ~cap_q;
  assign win_end = (win_q == SKW'(SKEW));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_COLLECT;
      ST_COLLECT: if ((&cap_d) || win_end) state_d = ST_VOTE;
      ST_VOTE:    state_d = ST_HOLD;
      ST_HOLD:    if (out_ack) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    encryption_ready = (state_q == ST_HOLD);
  end

  // Window counter is idle at 0 until the first capture, then counts 1..SKEW.
  always_comb begin
    cap_d     = cap_q;
    cap_ct_d  = cap_ct_q;
    cap_tag_d = cap_tag_q;
    win_d     = win_q;
    if (state_q == ST_IDLE && start) begin
      cap_d     = '0;
      cap_ct_d  = '0;
      cap_tag_d = '0;
      win_d     = '0;
    end else if (state_q == ST_COLLECT) begin
      for (int i = 0; i < NREP; i++) begin
        if (new_cap[i]) begin
          cap_ct_d[i*Y +: Y]  = rep_ct[i*Y +: Y];
          cap_tag_d[i*T +: T] = rep_tag[i*T +: T];
        end
      end
      cap_d = cap_q | new_cap;
      if ((win_q != '0 || new_cap != '0) && !win_end) win_d = win_q + SKW'(1);
    end
  end

  fc_bit_majority #(.W(Y), .NREP(NREP)) u_maj_ct (
    .vec_i (cap_ct_q),
    .maj_o (maj_ct)
  );

  fc_bit_majority #(.W(T), .NREP(NREP)) u_maj_tag (
    .vec_i (cap_tag_q),
    .maj_o (maj_tag)
  );

  always_comb begin
    match = '0;
    for (int i = 0; i < NREP; i++) begin
      if (cap_q[i] && cap_ct_q[i*Y +: Y] == maj_ct && cap_tag_q[i*T +: T] == maj_tag)
        match = match + MW'(1);
    end
  end

  assign vote_fault = (match != MW'(NREP));
  assign vote_ok    = (match >= MW'(QUORUM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q     <= '0;
      cap_ct_q  <= '0;
      cap_tag_q <= '0;
      win_q     <= '0;
      ct_q      <= '0;
      tag_q     <= '0;
      fd_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      cap_ct_q  <= cap_ct_d;
      cap_tag_q <= cap_tag_d;
      win_q     <= win_d;
      if (state_q == ST_IDLE && start) to_q <= 1'b0;
      if (state_q == ST_COLLECT && state_d == ST_VOTE && !(&cap_d)) to_q <= 1'b1;
      if (state_q == ST_VOTE) begin
        ct_q  <= vote_ok ? maj_ct  : random_fault_ct;
        tag_q <= vote_ok ? maj_tag : random_fault_tag;
        fd_q  <= vote_fault;
      end
    end
  end

  assign cipher_text  = ct_q;
  assign tag          = tag_q;
  assign fault_detect = fd_q;
  assign skew_timeout = to_q;

`ifdef FC_FAULT_CNT_EN
  logic [CW-1:0] fcnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fcnt_q <= '0;
    else if (state_q == ST_VOTE && vote_fault && fcnt_q != '1) fcnt_q <= fcnt_q + CW'(1);
  end

  assign fault_count = fcnt_q;
`else
  assign fault_count = '0;
`endif

endmodule

// File: tb/tb_fc_vote_seq.sv
// Self-checking bench for fc_vote_seq against a behavioural vote model.
module tb_fc_vote_seq;

  localparam int NREP = 3;
  localparam int Y    = 40;
  localparam int T    = 128;
  localparam int SKEW = 4;
  localparam int CW   = 8;

  logic              clk = 1'b0;
  logic              rst, start, out_ack;
  logic [NREP-1:0]   rep_ready;
  logic [NREP*Y-1:0] rep_ct;
  logic [NREP*T-1:0] rep_tag;
  logic [Y-1:0]      random_fault_ct, cipher_text;
  logic [T-1:0]      random_fault_tag, tag;
  logic              encryption_ready, fault_detect, skew_timeout;
  logic [CW-1:0]     fault_count;

  int total = 0;
  int bad   = 0;
  int model_faults = 0;

  logic [Y-1:0] sc_ct[NREP];
  logic [T-1:0] sc_tag[NREP];
  int           sc_off[NREP];

  always #5 clk = ~clk;

  fc_vote_seq #(.NREP(NREP), .Y(Y), .T(T), .SKEW(SKEW), .CW(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .rep_ready        (rep_ready),
    .rep_ct           (rep_ct),
    .rep_tag          (rep_tag),
    .random_fault_ct  (random_fault_ct),
    .random_fault_tag (random_fault_tag),
    .out_ack          (out_ack),
    .cipher_text      (cipher_text),
    .tag              (tag),
    .encryption_ready (encryption_ready),
    .fault_detect     (fault_detect),
    .skew_timeout     (skew_timeout),
    .fault_count      (fault_count)
  );

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int exp_fc();
`ifdef FC_FAULT_CNT_EN
    return model_faults;
`else
    return 0;
`endif
  endfunction

  function automatic logic [T-1:0] rand_t();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [Y-1:0] rand_y();
    return Y'({$urandom, $urandom});
  endfunction

  // Runs one operation using sc_ct/sc_tag/sc_off; offset -1 means never ready.
  task automatic run_op(input string name, input int hold_n, input bit ack_start);
    int min_o, max_o, exp_edges, n_edges, ones, match;
    bit all_cap, fd, ok, got;
    bit capd[NREP];
    logic [Y-1:0] cct[NREP];
    logic [T-1:0] ctag[NREP];
    logic [Y-1:0] mct, ect;
    logic [T-1:0] mtag, etag;

    random_fault_ct  = rand_y();
    random_fault_tag = rand_t();
    min_o = 1000;
    max_o = -1;
    for (int i = 0; i < NREP; i++) begin
      if (sc_off[i] >= 0) begin
        if (sc_off[i] < min_o) min_o = sc_off[i];
        if (sc_off[i] > max_o) max_o = sc_off[i];
      end
    end
    all_cap = 1'b1;
    for (int i = 0; i < NREP; i++) begin
      capd[i] = (sc_off[i] >= 0) && (sc_off[i] - min_o <= SKEW);
      if (!capd[i]) all_cap = 1'b0;
      cct[i]  = capd[i] ? sc_ct[i]  : '0;
      ctag[i] = capd[i] ? sc_tag[i] : '0;
    end
    for (int b = 0; b < Y; b++) begin
      ones = 0;
      for (int i = 0; i < NREP; i++) ones += int'(cct[i][b]);
      mct[b] = (ones > NREP / 2);
    end
    for (int b = 0; b < T; b++) begin
      ones = 0;
      for (int i = 0; i < NREP; i++) ones += int'(ctag[i][b]);
      mtag[b] = (ones > NREP / 2);
    end
    match = 0;
    for (int i = 0; i < NREP; i++)
      if (capd[i] && cct[i] == mct && ctag[i] == mtag) match++;
    fd   = (match != NREP);
    ok   = (match >= NREP / 2 + 1);
    ect  = ok ? mct  : random_fault_ct;
    etag = ok ? mtag : random_fault_tag;
    if (fd && model_faults < (1 << CW) - 1) model_faults++;
    exp_edges = all_cap ? max_o + 2 : min_o + SKEW + 2;

    for (int i = 0; i < NREP; i++) begin
      rep_ct[i*Y +: Y]  = sc_ct[i];
      rep_tag[i*T +: T] = sc_tag[i];
    end
    @(negedge clk);
    start = 1'b1;
    rep_ready = '0;
    @(posedge clk);
    n_edges = 0;
    got = 1'b0;
    while (!got && n_edges < 40) begin
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NREP; i++) rep_ready[i] = (sc_off[i] >= 0) && (n_edges >= sc_off[i]);
      @(posedge clk);
      n_edges++;
      #1;
      if (encryption_ready) got = 1'b1;
    end
    chk({name, "/latency"}, 128'(n_edges), 128'(exp_edges));
    chk({name, "/ct"}, 128'(cipher_text), 128'(ect));
    chk({name, "/tag"}, tag, etag);
    chk({name, "/fault"}, 128'(fault_detect), 128'(fd));
    chk({name, "/timeout"}, 128'(skew_timeout), 128'(!all_cap));
    chk({name, "/fcount"}, 128'(fault_count), 128'(exp_fc()));

    for (int k = 0; k < hold_n; k++) begin
      @(negedge clk);
      start = (k == 2);
      random_fault_ct  = rand_y();
      random_fault_tag = rand_t();
      rep_ready = NREP'($urandom);
      @(posedge clk);
      #1;
      chk({name, "/hold_rdy"}, 128'(encryption_ready), 128'(1));
      chk({name, "/hold_ct"}, 128'(cipher_text), 128'(ect));
      chk({name, "/hold_tag"}, tag, etag);
    end

    @(negedge clk);
    start = ack_start;
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "/ack_rdy"}, 128'(encryption_ready), 128'(0));
    @(negedge clk);
    start = 1'b0;
    out_ack = 1'b0;
    rep_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk({name, "/idle_rdy"}, 128'(encryption_ready), 128'(0));
    chk({name, "/kept_ct"}, 128'(cipher_text), 128'(ect));
  endtask

  // Starts an operation, lets it sit in COLLECT, then resets asynchronously.
  task automatic reset_mid(input string name, input bit some_ready, input int wait_n);
    @(negedge clk);
    start = 1'b1;
    rep_ready = '0;
    @(posedge clk);
    for (int k = 0; k < wait_n; k++) begin
      @(negedge clk);
      start = 1'b0;
      rep_ready = some_ready ? NREP'(1) : '0;
      @(posedge clk);
    end
    #1;
    chk({name, "/pre_rdy"}, 128'(encryption_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({name, "/rst_ct"}, 128'(cipher_text), 128'(0));
    chk({name, "/rst_tag"}, tag, 128'(0));
    chk({name, "/rst_flags"}, 128'({encryption_ready, fault_detect, skew_timeout}), 128'(0));
    chk({name, "/rst_fcount"}, 128'(fault_count), 128'(0));
    model_faults = 0;
    rep_ready = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_all(input logic [Y-1:0] ct, input logic [T-1:0] tg);
    for (int i = 0; i < NREP; i++) begin
      sc_ct[i]  = ct;
      sc_tag[i] = tg;
      sc_off[i] = 0;
    end
  endtask

  initial begin
    logic [Y-1:0] base_ct;
    logic [T-1:0] base_tag;
    int r;

    rst = 1'b0;
    start = 1'b0;
    out_ack = 1'b0;
    rep_ready = '0;
    rep_ct = '0;
    rep_tag = '0;
    random_fault_ct = '0;
    random_fault_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/ct", 128'(cipher_text), 128'(0));
    chk("reset/tag", tag, 128'(0));
    chk("reset/flags", 128'({encryption_ready, fault_detect, skew_timeout}), 128'(0));
    chk("reset/fcount", 128'(fault_count), 128'(0));
    @(negedge clk);
    rst = 1'b1;

    base_tag = rand_t();
    set_all(40'h12_3456_789A, base_tag);
    run_op("same_cycle", 10, 1'b0);

    set_all(40'h12_3456_789A, base_tag);
    sc_ct[1] = sc_ct[1] ^ 40'h1;
    run_op("bitflip", 2, 1'b1);

    set_all(rand_y(), rand_t());
    sc_off[1] = 2;
    sc_off[2] = 3;
    run_op("skewed", 0, 1'b0);

    set_all(rand_y(), rand_t());
    sc_off[2] = -1;
    run_op("missing", 0, 1'b0);

    base_ct = rand_y();
    set_all(base_ct, rand_t());
    sc_ct[1] = base_ct ^ 40'h1;
    sc_ct[2] = base_ct ^ 40'h2;
    run_op("all_differ", 0, 1'b0);

    reset_mid("rst_collect", 1'b1, 3);
    set_all(40'h12_3456_789A, base_tag);
    run_op("after_rst", 0, 1'b0);

    reset_mid("no_ready", 1'b0, 15);

    for (int n = 0; n < 8; n++) begin
      base_ct  = rand_y();
      base_tag = rand_t();
      set_all(base_ct, base_tag);
      for (int i = 0; i < NREP; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 3) sc_ct[i]  = sc_ct[i] ^ (Y'(1) << $urandom_range(0, Y - 1));
        else if (r < 5) sc_tag[i] = sc_tag[i] ^ (T'(1) << $urandom_range(0, T - 1));
        sc_off[i] = int'($urandom_range(0, 6));
        if (i != 0 && $urandom_range(0, 4) == 0) sc_off[i] = -1;
      end
      run_op($sformatf("rand%0d", n), 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
